// File: rtl/shared_hpc3_mul_feed.sv
// Operand/randomness feeder for a shared GF(4) HPC3 multiplier: a 2-deep randomness FIFO,
// an issue register stage and a valid pipeline. Optional macro: SHARED_FEED_ZEROIZE_EN.
module shared_hpc3_mul_feed #(
  parameter int unsigned SHARES = 4
) (
  input  logic                              ClkxCI,
  input  logic                              RstxRI,
  input  logic                              InValidxSI,
  output logic                              InReadyxSO,
  input  logic [4*SHARES-1:0]               _XxDI,
  input  logic [4*SHARES-1:0]               _YxDI,
  input  logic                              RandValidxSI,
  output logic                              RandReadyxSO,
  input  logic [4*SHARES*(SHARES-1)-1:0]    _RandxDI,
  output logic [4*SHARES-1:0]               _XxDO,
  output logic [4*SHARES-1:0]               _XxDO_prev,
  output logic [4*SHARES-1:0]               _YxDO,
  output logic [2*SHARES*(SHARES-1)-1:0]    _ZxDO,
  output logic [2*SHARES*(SHARES-1)-1:0]    _RxDO,
  output logic                              MulValidxSO,
  output logic                              OutValidxSO,
  output logic [15:0]                       OpCountxDO
);

  localparam int unsigned DW = 4 * SHARES;
  localparam int unsigned RW = 4 * SHARES * (SHARES - 1);
  localparam int unsigned HW = RW / 2;

  logic [1:0]    count_q, count_d;
  logic [RW-1:0] fifo0_q, fifo0_d;
  logic [RW-1:0] fifo1_q, fifo1_d;
  logic          mul_valid_q, mul_valid_d;
  logic          out_valid_q, out_valid_d;
  logic [15:0]   op_count_q, op_count_d;
  logic [DW-1:0] x_q, x_d;
  logic [DW-1:0] y_q, y_d;
  logic [DW-1:0] x_prev_q, x_prev_d;
  logic [HW-1:0] z_q, z_d;
  logic [HW-1:0] r_q, r_d;

  logic have_word;
  logic issue;
  logic rand_ready;
  logic push;

  // Handshake: reset gates everything so nothing moves while RstxRI is high.
  always_comb begin
    have_word  = (count_q != 2'd0);
    issue      = ~RstxRI & InValidxSI & have_word;
    rand_ready = ~RstxRI & ((count_q < 2'd2) | issue);
    push       = RandValidxSI & rand_ready;
  end

  // fifo0 is always the head; pop shifts fifo1 forward.
  always_comb begin
    count_d = count_q;
    fifo0_d = fifo0_q;
    fifo1_d = fifo1_q;
    case ({push, issue})
      2'b10: begin
        if (count_q == 2'd0) begin
          fifo0_d = _RandxDI;
        end else begin
          fifo1_d = _RandxDI;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        fifo0_d = fifo1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          fifo0_d = _RandxDI;
        end else begin
          fifo0_d = fifo1_q;
          fifo1_d = _RandxDI;
        end
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    mul_valid_d = issue;
    out_valid_d = mul_valid_q;
    op_count_d  = op_count_q + 16'(issue);
    x_prev_d    = mul_valid_q ? x_q : x_prev_q;
    if (issue) begin
      x_d = _XxDI;
      y_d = _YxDI;
      z_d = fifo0_q[HW-1:0];
      r_d = fifo0_q[RW-1:HW];
    end else begin
`ifdef SHARED_FEED_ZEROIZE_EN
      x_d = '0;
      y_d = '0;
      z_d = '0;
      r_d = '0;
`else
      x_d = x_q;
      y_d = y_q;
      z_d = z_q;
      r_d = r_q;
`endif
    end
  end

  always_ff @(posedge ClkxCI) begin
    if (RstxRI) begin
      count_q     <= '0;
      fifo0_q     <= '0;
      fifo1_q     <= '0;
      mul_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      op_count_q  <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      r_q         <= '0;
      x_prev_q    <= '0;
    end else begin
      count_q     <= count_d;
      fifo0_q     <= fifo0_d;
      fifo1_q     <= fifo1_d;
      mul_valid_q <= mul_valid_d;
      out_valid_q <= out_valid_d;
      op_count_q  <= op_count_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      r_q         <= r_d;
      x_prev_q    <= x_prev_d;
    end
  end

  // Valids are masked by reset so the cycle in which reset is first sampled already reads idle.
  always_comb begin
    InReadyxSO   = ~RstxRI & have_word;
    RandReadyxSO = rand_ready;
    MulValidxSO  = ~RstxRI & mul_valid_q;
    OutValidxSO  = ~RstxRI & out_valid_q;
    OpCountxDO   = op_count_q;
    _XxDO        = x_q;
    _YxDO        = y_q;
    _ZxDO        = z_q;
    _RxDO        = r_q;
    _XxDO_prev   = x_prev_q;
  end

endmodule

// File: tb/tb_shared_hpc3_mul_feed.sv
// Self-checking bench for shared_hpc3_mul_feed: directed scenarios plus randomized traffic
// checked against a queue-based history model of issues and randomness words.
module tb_shared_hpc3_mul_feed;
  localparam int unsigned S  = 4;
  localparam int unsigned DW = 4 * S;
  localparam int unsigned RW = 4 * S * (S - 1);
  localparam int unsigned HW = RW / 2;
`ifdef SHARED_FEED_ZEROIZE_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          rand_valid = 1'b0;
  logic [DW-1:0] x_in = '0;
  logic [DW-1:0] y_in = '0;
  logic [RW-1:0] rand_in = '0;

  logic          InReadyxSO, RandReadyxSO, MulValidxSO, OutValidxSO;
  logic [DW-1:0] _XxDO, _XxDO_prev, _YxDO;
  logic [HW-1:0] _ZxDO, _RxDO;
  logic [15:0]   OpCountxDO;

  shared_hpc3_mul_feed #(.SHARES(S)) dut (
    .ClkxCI      (clk),
    .RstxRI      (rst),
    .InValidxSI  (in_valid),
    .InReadyxSO  (InReadyxSO),
    ._XxDI       (x_in),
    ._YxDI       (y_in),
    .RandValidxSI(rand_valid),
    .RandReadyxSO(RandReadyxSO),
    ._RandxDI    (rand_in),
    ._XxDO       (_XxDO),
    ._XxDO_prev  (_XxDO_prev),
    ._YxDO       (_YxDO),
    ._ZxDO       (_ZxDO),
    ._RxDO       (_RxDO),
    .MulValidxSO (MulValidxSO),
    .OutValidxSO (OutValidxSO),
    .OpCountxDO  (OpCountxDO)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct packed {
    int            c;
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic [RW-1:0] w;
  } iss_t;

  iss_t          log_q[$];
  logic [RW-1:0] rq[$];
  logic [15:0]   opcnt = '0;

  function automatic bit model_issue();
    return !rst && in_valid && (rq.size() > 0);
  endfunction

  function automatic bit issued_at(int c);
    foreach (log_q[i]) if (log_q[i].c == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [19:0] exp_ctrl();
    bit ir, rr, mv, ov;
    ir = !rst && (rq.size() > 0);
    rr = !rst && ((rq.size() < 2) || model_issue());
    mv = !rst && issued_at(cyc - 1);
    ov = !rst && issued_at(cyc - 2);
    return {ir, rr, mv, ov, opcnt};
  endfunction

  function automatic logic [3*DW+RW-1:0] exp_data();
    logic [DW-1:0] ex, ey, ep;
    logic [RW-1:0] ew;
    ex = '0; ey = '0; ep = '0; ew = '0;
    for (int i = 0; i < log_q.size(); i++) begin
      if (log_q[i].c <= cyc - 1) begin
        ex = log_q[i].x; ey = log_q[i].y; ew = log_q[i].w;
      end
      if (log_q[i].c <= cyc - 2) ep = log_q[i].x;
    end
    if (ZERO && !issued_at(cyc - 1)) begin
      ex = '0; ey = '0; ew = '0;
    end
    return {ex, ey, ew[HW-1:0], ew[RW-1:HW], ep};
  endfunction

  task automatic tick();
    bit iss, acc;
    iss = model_issue();
    acc = !rst && rand_valid && ((rq.size() < 2) || iss);
    @(posedge clk);
    if (rst) begin
      rq.delete();
      log_q.delete();
      opcnt = '0;
    end else begin
      if (iss) begin
        log_q.push_back('{c: cyc, x: x_in, y: y_in, w: rq[0]});
        void'(rq.pop_front());
        opcnt++;
      end
      if (acc) rq.push_back(rand_in);
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; rand_valid = 1'b0;
    tick();
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      checks++;
      if ({InReadyxSO, RandReadyxSO, MulValidxSO, OutValidxSO, OpCountxDO} !== 20'h0) begin
        errors++;
        $display("FAIL reset_ctrl cyc=%0d got %h exp 0", cyc, {InReadyxSO, RandReadyxSO, MulValidxSO, OutValidxSO, OpCountxDO});
      end
      checks++;
      if ({_XxDO, _YxDO, _ZxDO, _RxDO, _XxDO_prev} !== '0) begin
        errors++;
        $display("FAIL reset_data cyc=%0d got %h exp 0", cyc, {_XxDO, _YxDO, _ZxDO, _RxDO, _XxDO_prev});
      end
      tick();
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({InReadyxSO, RandReadyxSO} !== 2'b01) begin
      errors++;
      $display("FAIL reset_release got in_rdy=%b rand_rdy=%b exp in_rdy=0 rand_rdy=1", InReadyxSO, RandReadyxSO);
    end
    tick();
  endtask

  task automatic test_directed();
    logic [RW-1:0] w;
    w = {6{8'hA5}};
    rand_valid = 1'b1; rand_in = w; in_valid = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      checks++;
      if ({InReadyxSO, RandReadyxSO, MulValidxSO, OutValidxSO, OpCountxDO} !== exp_ctrl()) begin
        errors++;
        $display("FAIL directed_ctrl cyc=%0d got %h exp %h", cyc, {InReadyxSO, RandReadyxSO, MulValidxSO, OutValidxSO, OpCountxDO}, exp_ctrl());
      end
      checks++;
      if ({_XxDO, _YxDO, _ZxDO, _RxDO, _XxDO_prev} !== exp_data()) begin
        errors++;
        $display("FAIL directed_data cyc=%0d got %h exp %h", cyc, {_XxDO, _YxDO, _ZxDO, _RxDO, _XxDO_prev}, exp_data());
      end
      if (n == 2) begin
        checks++;
        if ({MulValidxSO, _XxDO, _YxDO, _ZxDO, _RxDO} !== {1'b1, 16'h1234, 16'h5678, 24'hA5A5A5, 24'hA5A5A5}) begin
          errors++;
          $display("FAIL directed_mul got mv=%b x=%h y=%h z=%h r=%h", MulValidxSO, _XxDO, _YxDO, _ZxDO, _RxDO);
        end
      end
      if (n == 3) begin
        checks++;
        if ({OutValidxSO, _XxDO_prev, OpCountxDO} !== {1'b1, 16'h1234, 16'd1}) begin
          errors++;
          $display("FAIL directed_out got ov=%b xprev=%h cnt=%0d exp ov=1 xprev=1234 cnt=1", OutValidxSO, _XxDO_prev, OpCountxDO);
        end
      end
      tick();
      rand_valid = 1'b0;
      in_valid = (n == 0);
      x_in = 16'h1234; y_in = 16'h5678;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_starve();
    int mv_seen;
    mv_seen = 0;
    in_valid = 1'b1; rand_valid = 1'b0;
    for (int n = 0; n < 10; n++) begin
      x_in = DW'($urandom()); y_in = DW'($urandom());
      rand_valid = (n == 5);
      rand_in = RW'({$urandom(), $urandom()});
      @(negedge clk);
      if (n < 6) begin
        checks++;
        if ({InReadyxSO, MulValidxSO} !== 2'b00) begin
          errors++;
          $display("FAIL starve_idle n=%0d got in_rdy=%b mv=%b exp 0 0", n, InReadyxSO, MulValidxSO);
        end
      end
      if (n >= 5) mv_seen += int'(MulValidxSO);
      checks++;
      if ({InReadyxSO, RandReadyxSO, MulValidxSO, OutValidxSO, OpCountxDO} !== exp_ctrl()) begin
        errors++;
        $display("FAIL starve_ctrl cyc=%0d got %h exp %h", cyc, {InReadyxSO, RandReadyxSO, MulValidxSO, OutValidxSO, OpCountxDO}, exp_ctrl());
      end
      checks++;
      if ({_XxDO, _YxDO, _ZxDO, _RxDO, _XxDO_prev} !== exp_data()) begin
        errors++;
        $display("FAIL starve_data cyc=%0d got %h exp %h", cyc, {_XxDO, _YxDO, _ZxDO, _RxDO, _XxDO_prev}, exp_data());
      end
      tick();
    end
    checks++;
    if (mv_seen !== 1) begin
      errors++;
      $display("FAIL starve_one_issue got %0d mul_valid pulses exp 1", mv_seen);
    end
    in_valid = 1'b0; rand_valid = 1'b0;
  endtask

  task automatic test_full();
    for (int n = 0; n < 9; n++) begin
      rand_in = RW'({$urandom(), $urandom()});
      x_in = DW'($urandom()); y_in = DW'($urandom());
      rand_valid = (n <= 3);
      in_valid = (n == 2) || (n >= 4 && n <= 6);
      @(negedge clk);
      if (n == 2) begin
        checks++;
        if ({InReadyxSO, RandReadyxSO} !== 2'b11) begin
          errors++;
          $display("FAIL full_push_pop got in_rdy=%b rand_rdy=%b exp 1 1", InReadyxSO, RandReadyxSO);
        end
      end
      if (n == 3) begin
        checks++;
        if ({InReadyxSO, RandReadyxSO} !== 2'b10) begin
          errors++;
          $display("FAIL full_still2 got in_rdy=%b rand_rdy=%b exp 1 0", InReadyxSO, RandReadyxSO);
        end
      end
      checks++;
      if ({InReadyxSO, RandReadyxSO, MulValidxSO, OutValidxSO, OpCountxDO} !== exp_ctrl()) begin
        errors++;
        $display("FAIL full_ctrl cyc=%0d got %h exp %h", cyc, {InReadyxSO, RandReadyxSO, MulValidxSO, OutValidxSO, OpCountxDO}, exp_ctrl());
      end
      checks++;
      if ({_XxDO, _YxDO, _ZxDO, _RxDO, _XxDO_prev} !== exp_data()) begin
        errors++;
        $display("FAIL full_data cyc=%0d got %h exp %h", cyc, {_XxDO, _YxDO, _ZxDO, _RxDO, _XxDO_prev}, exp_data());
      end
      tick();
    end
    in_valid = 1'b0; rand_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] bx[4];
    int ov_cnt, first_ov, last_ov;
    ov_cnt = 0; first_ov = -1; last_ov = -1;
    for (int n = 0; n < 9; n++) begin
      rand_valid = (n <= 4);
      rand_in = RW'({$urandom(), $urandom()});
      in_valid = (n >= 1 && n <= 4);
      x_in = DW'($urandom()); y_in = DW'($urandom());
      if (in_valid) bx[n-1] = x_in;
      @(negedge clk);
      if (OutValidxSO === 1'b1) begin
        if (first_ov < 0) first_ov = n;
        last_ov = n;
        if (ov_cnt < 4) begin
          checks++;
          if (_XxDO_prev !== bx[ov_cnt]) begin
            errors++;
            $display("FAIL b2b_xprev k=%0d got %h exp %h", ov_cnt, _XxDO_prev, bx[ov_cnt]);
          end
        end
        ov_cnt++;
      end
      checks++;
      if ({InReadyxSO, RandReadyxSO, MulValidxSO, OutValidxSO, OpCountxDO} !== exp_ctrl()) begin
        errors++;
        $display("FAIL b2b_ctrl cyc=%0d got %h exp %h", cyc, {InReadyxSO, RandReadyxSO, MulValidxSO, OutValidxSO, OpCountxDO}, exp_ctrl());
      end
      checks++;
      if ({_XxDO, _YxDO, _ZxDO, _RxDO, _XxDO_prev} !== exp_data()) begin
        errors++;
        $display("FAIL b2b_data cyc=%0d got %h exp %h", cyc, {_XxDO, _YxDO, _ZxDO, _RxDO, _XxDO_prev}, exp_data());
      end
      tick();
    end
    checks++;
    if (ov_cnt !== 4 || (last_ov - first_ov) !== 3) begin
      errors++;
      $display("FAIL b2b_pulses got count=%0d span=%0d exp count=4 span=3", ov_cnt, last_ov - first_ov);
    end
    in_valid = 1'b0; rand_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int ov_after;
    ov_after = 0;
    for (int n = 0; n < 8; n++) begin
      rand_valid = (n == 0);
      rand_in = RW'({$urandom(), $urandom()});
      in_valid = (n == 1);
      x_in = DW'($urandom()); y_in = DW'($urandom());
      rst = (n == 2);
      @(negedge clk);
      if (n >= 3) begin
        ov_after += int'(OutValidxSO);
        checks++;
        if ({OpCountxDO, _XxDO, _YxDO, _ZxDO, _RxDO, _XxDO_prev} !== '0) begin
          errors++;
          $display("FAIL rstmid_zero n=%0d got cnt=%0d data=%h exp 0", n, OpCountxDO, {_XxDO, _YxDO, _ZxDO, _RxDO, _XxDO_prev});
        end
      end
      checks++;
      if ({InReadyxSO, RandReadyxSO, MulValidxSO, OutValidxSO, OpCountxDO} !== exp_ctrl()) begin
        errors++;
        $display("FAIL rstmid_ctrl cyc=%0d got %h exp %h", cyc, {InReadyxSO, RandReadyxSO, MulValidxSO, OutValidxSO, OpCountxDO}, exp_ctrl());
      end
      tick();
    end
    checks++;
    if (ov_after !== 0) begin
      errors++;
      $display("FAIL rstmid_outvalid got %0d pulses after reset exp 0", ov_after);
    end
    rst = 1'b0; in_valid = 1'b0; rand_valid = 1'b0;
  endtask

  task automatic test_idle_hold();
    logic [DW-1:0] xi, xe;
    xi = DW'($urandom());
    for (int n = 0; n < 6; n++) begin
      rand_valid = (n == 0);
      rand_in = RW'({$urandom(), $urandom()});
      in_valid = (n == 1);
      x_in = (n == 1) ? xi : DW'($urandom());
      y_in = DW'($urandom());
      @(negedge clk);
      if (n >= 3) begin
        xe = ZERO ? '0 : xi;
        checks++;
        if (_XxDO !== xe) begin
          errors++;
          $display("FAIL idle_hold n=%0d got %h exp %h", n, _XxDO, xe);
        end
      end
      checks++;
      if ({_XxDO, _YxDO, _ZxDO, _RxDO, _XxDO_prev} !== exp_data()) begin
        errors++;
        $display("FAIL idle_data cyc=%0d got %h exp %h", cyc, {_XxDO, _YxDO, _ZxDO, _RxDO, _XxDO_prev}, exp_data());
      end
      tick();
    end
    in_valid = 1'b0; rand_valid = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(63) == 0);
      in_valid = $urandom_range(1);
      rand_valid = $urandom_range(1);
      x_in = DW'($urandom()); y_in = DW'($urandom());
      rand_in = RW'({$urandom(), $urandom()});
      @(negedge clk);
      checks++;
      if ({InReadyxSO, RandReadyxSO, MulValidxSO, OutValidxSO, OpCountxDO} !== exp_ctrl()) begin
        errors++;
        $display("FAIL rand_ctrl cyc=%0d got %h exp %h", cyc, {InReadyxSO, RandReadyxSO, MulValidxSO, OutValidxSO, OpCountxDO}, exp_ctrl());
      end
      checks++;
      if ({_XxDO, _YxDO, _ZxDO, _RxDO, _XxDO_prev} !== exp_data()) begin
        errors++;
        $display("FAIL rand_data cyc=%0d got %h exp %h", cyc, {_XxDO, _YxDO, _ZxDO, _RxDO, _XxDO_prev}, exp_data());
      end
      tick();
    end
    rst = 1'b0; in_valid = 1'b0; rand_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_starve();
    test_full();
    test_back_to_back();
    test_idle_hold();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shared_hpc3_mul_feed.md
SHARED_HPC3_MUL_FEED -- requirements
Module: shared_hpc3_mul_feed

Interface
REQ-001 SHALL have parameter SHARES, default 4, number of Boolean shares per GF(4) operand (2..8).
REQ-002 SHALL have ports, in order:
- ClkxCI  in  1  single clock, rising edge.
- RstxRI  in  1  reset, synchronous, active-high.
- InValidxSI  in  1  operand pair offered.
- InReadyxSO  out  1  operand pair accepted this cycle.
- _XxDI  in  4*SHARES  shared X, share i at bits [4i+3:4i].
- _YxDI  in  4*SHARES  shared Y, same packing.
- RandValidxSI  in  1  fresh randomness word offered.
- RandReadyxSO  out  1  randomness word accepted this cycle.
- _RandxDI  in  4*SHARES*(SHARES-1)  Z in low half, R in high half.
- _XxDO  out  4*SHARES  X to multiplier.
- _XxDO_prev  out  4*SHARES  X issued on the previous MulValid cycle.
- _YxDO  out  4*SHARES  Y to multiplier.
- _ZxDO  out  2*SHARES*(SHARES-1)  Z to multiplier.
- _RxDO  out  2*SHARES*(SHARES-1)  R to multiplier.
- MulValidxSO  out  1  multiplier inputs valid this cycle.
- OutValidxSO  out  1  multiplier _QxDO valid this cycle.
- OpCountxDO  out  16  number of issued operations.

Function
REQ-003 SHALL buffer randomness in a 2-entry FIFO; RandReadyxSO = (count<2) or (count==2 and pop this cycle).
REQ-004 SHALL push when RandValidxSI and RandReadyxSO; SHALL pop on issue; simultaneous push and pop SHALL leave count unchanged, including at count 2.
REQ-005 SHALL issue in cycle t iff InValidxSI and FIFO count>0; InReadyxSO SHALL equal (count>0), independent of InValidxSI.
REQ-006 On issue at t, SHALL register X, Y and the FIFO head (Z = low half, R = high half) onto _XxDO/_YxDO/_ZxDO/_RxDO and assert MulValidxSO in cycle t+1.
REQ-007 SHALL assert OutValidxSO in cycle t+2 for every issue at t (2-stage valid shift register); back-to-back issues SHALL yield back-to-back OutValid pulses.
REQ-008 SHALL load _XxDO_prev from _XxDO on every cycle MulValidxSO=1 and hold otherwise, so in cycle t+2 _XxDO_prev equals the X issued at t.
REQ-009 SHALL use each randomness word for exactly one issue; no word is reused or skipped.
REQ-010 SHALL increment OpCountxDO by 1 per issue, wrapping 0xFFFF -> 0x0000.
REQ-011 SHALL keep _XxDO/_YxDO/_ZxDO/_RxDO unchanged in cycles with MulValidxSO=0, except as in REQ-017.
REQ-012 SHALL not combine shares of different indices in any logic; share i of every output depends only on share i of inputs plus randomness.

Reset
REQ-013 RstxRI high at a clock edge SHALL clear FIFO count, both valid-pipeline stages, OpCountxDO, and all data output registers to zero.
REQ-014 During reset, InReadyxSO, RandReadyxSO, MulValidxSO and OutValidxSO SHALL be 0; no push, pop or issue occurs.
REQ-015 Reset mid-operation SHALL discard in-flight operations; no OutValid pulse from a pre-reset issue SHALL appear after reset deasserts.
REQ-016 First cycle after reset deassertion SHALL accept randomness (RandReadyxSO=1) but SHALL not issue (count=0).

Configuration
REQ-017 Macro SHARED_FEED_ZEROIZE_EN defined: in every cycle MulValidxSO=0, _XxDO/_YxDO/_ZxDO/_RxDO SHALL be zero (registered; _XxDO_prev unaffected). Undefined: outputs hold last issued values per REQ-011.

Verification
REQ-018 Bench SHALL cover:
- SHARES=4, one rand word 0xA5..A5 pushed, then X=0x1234, Y=0x5678 with InValid -> MulValid at t+1 with _ZxDO=low half, _RxDO=high half; OutValid at t+2; _XxDO_prev=0x1234; OpCountxDO=1.
- InValid held 5 cycles, no randomness -> InReadyxSO=0, no MulValid; push one word -> exactly one issue next cycle.
- FIFO full (count=2), RandValid and issue same cycle -> word accepted, count stays 2, RandReadyxSO=1.
- 4 back-to-back issues with continuous randomness -> 4 consecutive OutValid pulses; _XxDO_prev each cycle equals prior _XxDO.
- Reset asserted one cycle after an issue -> no OutValid afterwards, OpCountxDO=0, all outputs 0.
- With SHARED_FEED_ZEROIZE_EN, idle cycle after issue -> data outputs 0; without, outputs equal last issued values.
